// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 line inputs and received-byte strobes.
// Ports (signals): PS2_CLK, PS2_DAT raw lines; rx_data[7:0], rx_valid, rx_err.
// master: receiver side (samples lines, drives rx_*).
// slave : device/consumer side (drives lines, reads rx_*).
interface ps2_rx_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        input  PS2_CLK,
        input  PS2_DAT,
        output rx_data,
        output rx_valid,
        output rx_err
    );

    modport slave (
        output PS2_CLK,
        output PS2_DAT,
        input  rx_data,
        input  rx_valid,
        input  rx_err
    );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with line de-glitching and
// 11-bit frame deserialisation (start, 8 data LSB-first, parity, stop).
// Ports: clk_bus (system clock), bus_reset (sync, active-high),
//        bus (ps2_rx_if.master): PS2_CLK/PS2_DAT in, rx_data/rx_valid/rx_err out.
// Option: define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic           clk_bus,
    input  logic           bus_reset,
    ps2_rx_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0]  FLEN = 8'(FILTER_LEN);
    localparam logic [19:0] TOUT = 20'(TIMEOUT_CYC);

    // index 0: clock line, index 1: data line
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_filt;
    logic [7:0] r_fcnt [2];
    logic       r_clk_d;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_bit;
    logic [7:0] r_shreg;
    logic       r_par;
    logic [19:0] r_to_cnt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_err;

    logic       w_fall;
    logic       w_dat;
    logic       w_timeout;
    logic       w_par_calc;
    logic       w_par_ok;
    logic       w_shift;
    logic       w_par_ld;
    logic       w_bit_clr;
    logic       w_bit_inc;
    logic       w_good;
    logic       w_bad;

    // Synchroniser and per-line persistence filter.
    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_fcnt[0] <= 8'd0;
            r_fcnt[1] <= 8'd0;
            r_clk_d   <= 1'b1;
        end else begin
            r_sync1 <= {bus.PS2_DAT, bus.PS2_CLK};
            r_sync2 <= r_sync1;
            r_clk_d <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= 8'd0;
                end else if (r_fcnt[i] + 8'd1 == FLEN) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= 8'd0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_fall = r_clk_d & ~r_filt[0];
    assign w_dat  = r_filt[1];

    // A fall in the expiry cycle keeps the frame alive.
    assign w_timeout = (r_state != S_IDLE) &&
                       (r_to_cnt == TOUT) && !w_fall;

    // Odd parity: data bits plus parity bit must XOR to 1.
    assign w_par_calc = ^{r_shreg, r_par};
`ifdef PS2_RX_PARITY_CHECK_EN
    assign w_par_ok = w_par_calc;
`else
    assign w_par_ok = w_par_calc | 1'b1;
`endif

    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_par_ld  = 1'b0;
        w_bit_clr = 1'b0;
        w_bit_inc = 1'b0;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_dat) begin
                        w_next    = S_DATA;
                        w_bit_clr = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_next = S_PARITY;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
                S_PARITY: begin
                    w_par_ld = 1'b1;
                    w_next   = S_STOP;
                end
                S_STOP: begin
                    if (w_dat && w_par_ok) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_bad  = 1'b1;
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            r_bit      <= 3'd0;
            r_shreg    <= 8'd0;
            r_par      <= 1'b0;
            r_to_cnt   <= 20'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= w_good;
            r_rx_err   <= w_bad;
            if (w_good) begin
                r_rx_data <= r_shreg;
            end
            if (w_shift) begin
                r_shreg <= {w_dat, r_shreg[7:1]};
            end
            if (w_par_ld) begin
                r_par <= w_dat;
            end
            if (w_bit_clr) begin
                r_bit <= 3'd0;
            end else if (w_bit_inc) begin
                r_bit <= r_bit + 3'd1;
            end
            if (r_state == S_IDLE || w_fall) begin
                r_to_cnt <= 20'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 20'd1;
            end
        end
    end

    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_err   = r_rx_err;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames against ps2_rx with hand-computed results.
// Covers good, back-to-back, parity, stop, glitch, timeout and reset cases.
module tb_ps2_rx;

    localparam int H  = 40;
    localparam int TO = 300;

    logic clk_bus   = 1'b0;
    logic bus_reset = 1'b1;

    ps2_rx_if bus ();

    ps2_rx #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_bus  (clk_bus),
        .bus_reset(bus_reset),
        .bus      (bus.master)
    );

    always #5 clk_bus = ~clk_bus;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         err_n  = 0;
    int         both_n = 0;
    logic [7:0] got_q [$];
    int         bv;
    int         be;
    int         n;

    always @(negedge clk_bus) begin
        if (bus.rx_valid) got_q.push_back(bus.rx_data);
        if (bus.rx_err) err_n++;
        if (bus.rx_valid && bus.rx_err) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_bus);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch = 1'b0);
        bus.PS2_DAT = b;
        repeat (10) tick;
        if (glitch) begin
            bus.PS2_CLK = 1'b0;
            repeat (5) tick;
            bus.PS2_CLK = 1'b1;
        end
        repeat (H - 10) tick;
        bus.PS2_CLK = 1'b0;
        repeat (H) tick;
        bus.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic pflip = 1'b0,
                              input logic stop = 1'b1,
                              input int gbit = -1);
        logic [10:0] f;
        f = {stop, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], i == gbit);
    endtask

    task automatic mark;
        bv = got_q.size();
        be = err_n;
    endtask

    function automatic logic [7:0] gq(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    initial begin
        logic [7:0] d;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        repeat (3) tick;
        chk("rst_data", bus.rx_data, 8'h00);
        chk("rst_valid", bus.rx_valid, 1'b0);
        chk("rst_err", bus.rx_err, 1'b0);
        bus_reset = 1'b0;
        repeat (20) tick;

        mark();
        send_frame(8'h1C);
        repeat (20) tick;
        chk("f1c_cnt", got_q.size() - bv, 1);
        chk("f1c_val", gq(bv), 8'h1C);
        chk("f1c_data", bus.rx_data, 8'h1C);
        chk("f1c_err", err_n - be, 0);

        mark();
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        repeat (20) tick;
        chk("b2b_cnt", got_q.size() - bv, 3);
        chk("b2b_0", gq(bv), 8'hE0);
        chk("b2b_1", gq(bv + 1), 8'hF0);
        chk("b2b_2", gq(bv + 2), 8'h75);
        chk("b2b_err", err_n - be, 0);

        mark();
        send_frame(8'h1C, 1'b1);
        repeat (20) tick;
`ifdef PS2_RX_PARITY_CHECK_EN
        chk("par_err", err_n - be, 1);
        chk("par_cnt", got_q.size() - bv, 0);
        chk("par_data", bus.rx_data, 8'h75);
`else
        chk("par_err", err_n - be, 0);
        chk("par_cnt", got_q.size() - bv, 1);
        chk("par_data", bus.rx_data, 8'h1C);
`endif

        mark();
        send_frame(8'h5A, 1'b0, 1'b0);
        bus.PS2_DAT = 1'b1;
        repeat (20) tick;
        chk("stop_err", err_n - be, 1);
        chk("stop_cnt", got_q.size() - bv, 0);
        mark();
        send_frame(8'h29);
        repeat (20) tick;
        chk("after_cnt", got_q.size() - bv, 1);
        chk("after_val", gq(bv), 8'h29);
        chk("after_err", err_n - be, 0);

        mark();
        bus.PS2_CLK = 1'b0;
        repeat (5) tick;
        bus.PS2_CLK = 1'b1;
        repeat (30) tick;
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        repeat (20) tick;
        chk("gl_cnt", got_q.size() - bv, 1);
        chk("gl_val", gq(bv), 8'h1C);
        chk("gl_err", err_n - be, 0);

        mark();
        d = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        bus.PS2_DAT = 1'b1;
        n = H;
        while (!bus.rx_err && n < TO + 100) begin
            tick;
            n++;
        end
        chk("to_cyc", n, TO + 12);
        repeat (20) tick;
        chk("to_err", err_n - be, 1);
        chk("to_cnt", got_q.size() - bv, 0);
        mark();
        send_frame(8'h33);
        repeat (20) tick;
        chk("to_next", gq(bv), 8'h33);
        chk("to_ncnt", got_q.size() - bv, 1);

        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.PS2_DAT = 1'b1;
        bus_reset   = 1'b1;
        repeat (3) tick;
        bus_reset = 1'b0;
        repeat (TO + 50) tick;
        chk("mrst_cnt", got_q.size() - bv, 0);
        chk("mrst_err", err_n - be, 0);
        send_frame(8'h4B);
        repeat (20) tick;
        chk("mrst_next", gq(bv), 8'h4B);
        chk("mrst_ncnt", got_q.size() - bv, 1);

        chk("both_hi", both_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Low-level PS/2 device-to-host receiver sitting directly upstream of the BK keyboard bus peripheral. It synchronises and de-glitches the raw `PS2_CLK`/`PS2_DAT` lines and deserialises 11-bit PS/2 frames. It reports each good scan-code byte as a one-cycle `rx_data`/`rx_valid` strobe, which the keyboard peripheral consumes unconditionally. Errored or abandoned frames are dropped and flagged on `rx_err`. The block is receive-only and never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, 8: consecutive `clk_bus` cycles a synchronised line must differ from its filtered value before the filtered value follows; range 1..255.
- `TIMEOUT_CYC`, 100000: idle `clk_bus` cycles allowed between filtered PS/2 clock falling edges inside a frame; must be < 2^20.

- `clk_bus` in 1: single system clock; all logic on its rising edge.
- `bus_reset` in 1: synchronous, active-high reset.
- `PS2_CLK` in 1: raw PS/2 clock from the device, asynchronous.
- `PS2_DAT` in 1: raw PS/2 data from the device, asynchronous.
- `rx_data` out 8: last good byte received, LSB = first data bit; holds until the next good frame.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning.** Each input passes a 2-flop synchroniser, then a filter.
  - The filter has one 8-bit counter per line; the counter clears whenever the synchronised value equals the filtered value.
  - While the two differ, the counter increments; when it reaches `FILTER_LEN`, the filtered value takes the synchronised value and the counter clears.
  - `fall` is a one-cycle strobe when the filtered clock goes 1->0.
- **FSM states:** IDLE, DATA, PARITY, STOP. Each state acts only on `fall`, sampling the filtered data line.
  - IDLE: data=0 -> DATA with bit count 0. Data=1 is ignored; stay in IDLE with no error.
  - DATA: shift the sample into `shreg[7]` and shift right. After the 8th sample (count 7) -> PARITY; otherwise count+1.
  - PARITY: latch the parity bit -> STOP.
  - STOP:
    - Data=1 and parity good: `rx_data`<=`shreg`, pulse `rx_valid`.
    - Otherwise: pulse `rx_err`.
    - Either way -> IDLE.
- **Parity.** Odd: XOR of the 8 data bits and the parity bit must be 1.
- **Timeout counter.** 20 bits wide.
  - Held at 0 in IDLE; cleared on every `fall`; otherwise +1.
  - When it reaches `TIMEOUT_CYC` outside IDLE: pulse `rx_err`, go to IDLE, discard the partial byte.
- **Boundary rules:**
  - `fall` and timeout expiry in the same cycle: `fall` wins and the frame continues.
  - `rx_valid` and `rx_err` are never high together.
  - A new start bit is accepted on the first `fall` after returning to IDLE; no inter-frame gap is required.
- **Reset.**
  - Clears: FSM->IDLE, counters 0, `shreg` 0, `rx_data` 0, `rx_valid` 0, `rx_err` 0.
  - Sets: synchroniser and filtered values to 1 (idle bus).
  - Reset mid-frame discards the frame and produces no pulse.

## Timing
- Raw line edge to filtered change: 2 synchroniser cycles + `FILTER_LEN` cycles, i.e. 10 cycles at default.
- `fall` is asserted the cycle after the filtered clock changes.
- `rx_valid`/`rx_err` are registered and go high the cycle after the `fall` that samples the stop bit (or after timeout expiry). They are high for exactly 1 cycle.
- `rx_data` changes in the same cycle `rx_valid` rises.
- Throughput: one byte per 11 PS/2 clocks; no backpressure and no buffering.

## Configuration
- `PS2_RX_PARITY_CHECK_EN`
  - Defined: the parity rule above applies; bad parity -> `rx_err`, no `rx_valid`.
  - Undefined: the parity bit is sampled but ignored. Any frame with stop=1 produces `rx_valid`, and `rx_err` fires only for stop-bit or timeout errors.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at 12 kHz PS/2 clock -> single `rx_valid` pulse, `rx_data`=0x1C, `rx_err` never high.
- Back-to-back frames E0, F0, 75 -> three `rx_valid` pulses in order with exactly those values.
- Frame 0x1C with parity 1 -> `rx_err` pulse, no `rx_valid`, `rx_data` unchanged.
  - With `PS2_RX_PARITY_CHECK_EN` undefined, the same frame -> `rx_valid` with 0x1C.
- Frame 0x5A with stop=0 -> `rx_err` pulse. A following good 0x29 frame -> `rx_valid`, 0x29.
- 5-cycle low glitches on `PS2_CLK` (`FILTER_LEN`=8) during an idle bus and mid-frame -> no bit shifted; a subsequent 0x1C frame decodes correctly.
- Clock stopped after 5 data bits for `TIMEOUT_CYC` cycles -> `rx_err` pulse exactly at expiry, FSM in IDLE. A separate run asserts `bus_reset` mid-frame -> no pulses, and the next frame decodes correctly.
